// File: rtl/circle_scan_controller.sv
// 640x480@60 raster generator with a once-per-frame bouncing circle centre.
// Define CIRCLE_BOUNCE_EN to build the animation; otherwise the centre is fixed mid-screen.
module circle_scan_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int RADIUS   = 50,
  parameter int STEP     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_start,
  output logic [9:0] center_x,
  output logic [9:0] center_y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] X_INIT   = 10'(H_ACTIVE / 2);
  localparam logic [9:0] Y_INIT   = 10'(V_ACTIVE / 2);

  logic [9:0] r_hcount;
  logic [9:0] r_vcount;
  logic       w_lineEnd;
  logic       w_frameEnd;

  assign w_lineEnd  = (r_hcount == H_LAST);
  assign w_frameEnd = w_lineEnd && (r_vcount == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_hcount <= w_lineEnd ? 10'd0 : r_hcount + 10'd1;
      if (w_lineEnd) begin
        r_vcount <= (r_vcount == V_LAST) ? 10'd0 : r_vcount + 10'd1;
      end
    end
  end

  assign hcount = r_hcount;
  assign vcount = r_vcount;
  assign hsync  = !((r_hcount >= HS_FIRST) && (r_hcount <= HS_LAST));
  assign vsync  = !((r_vcount >= VS_FIRST) && (r_vcount <= VS_LAST));

  // The counters already read (0,0) during reset, so these two are gated by rst directly.
  assign active      = !rst && (r_hcount < H_ACT) && (r_vcount < V_ACT);
  assign frame_start = !rst && (r_hcount == 10'd0) && (r_vcount == 10'd0);

`ifdef CIRCLE_BOUNCE_EN
  localparam logic [10:0] X_MIN  = 11'(RADIUS);
  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] Y_MIN  = 11'(RADIUS);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - 1 - RADIUS);
  localparam logic [10:0] W_STEP = 11'(STEP);

  logic [9:0]  r_centerX;
  logic [9:0]  r_centerY;
  logic        r_dirX;
  logic        r_dirY;
  logic [10:0] w_curX;
  logic [10:0] w_curY;
  logic [10:0] w_nextX;
  logic [10:0] w_nextY;
  logic        w_nextDirX;
  logic        w_nextDirY;

  assign w_curX = {1'b0, r_centerX};
  assign w_curY = {1'b0, r_centerY};

  // Lower-bound test is written as cur < min+STEP so the subtraction can never wrap.
  always_comb begin
    w_nextX    = w_curX;
    w_nextY    = w_curY;
    w_nextDirX = r_dirX;
    w_nextDirY = r_dirY;
    if (r_dirX) begin
      if (w_curX + W_STEP > X_MAX) begin
        w_nextX    = X_MAX;
        w_nextDirX = 1'b0;
      end else begin
        w_nextX = w_curX + W_STEP;
      end
    end else if (w_curX < X_MIN + W_STEP) begin
      w_nextX    = X_MIN;
      w_nextDirX = 1'b1;
    end else begin
      w_nextX = w_curX - W_STEP;
    end
    if (r_dirY) begin
      if (w_curY + W_STEP > Y_MAX) begin
        w_nextY    = Y_MAX;
        w_nextDirY = 1'b0;
      end else begin
        w_nextY = w_curY + W_STEP;
      end
    end else if (w_curY < Y_MIN + W_STEP) begin
      w_nextY    = Y_MIN;
      w_nextDirY = 1'b1;
    end else begin
      w_nextY = w_curY - W_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_centerX <= X_INIT;
      r_centerY <= Y_INIT;
      r_dirX    <= 1'b1;
      r_dirY    <= 1'b1;
    end else if (w_frameEnd && enable) begin
      r_centerX <= w_nextX[9:0];
      r_centerY <= w_nextY[9:0];
      r_dirX    <= w_nextDirX;
      r_dirY    <= w_nextDirY;
    end
  end

  assign center_x = r_centerX;
  assign center_y = r_centerY;
`else
  logic w_unused;

  assign w_unused = enable;
  assign center_x = X_INIT;
  assign center_y = Y_INIT;
`endif

endmodule

// File: tb/tb_circle_scan_controller.sv
// Bench for circle_scan_controller: a reduced-timing instance exercises frames and bounces,
// a full 640x480 instance checks the real line timing; both follow a cycle-count reference model.
module tb_circle_scan_controller;

  localparam int S_HA = 16, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VA = 12, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_R = 3, S_STEP = 2;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FT = S_HT * S_VT;
  localparam int F_HT = 800, F_VT = 525;
  localparam int F_FT = F_HT * F_VT;

  logic       clk, rst, enable;
  logic [9:0] sH, sV, sCx, sCy, fH, fV, fCx, fCy;
  logic       sHs, sVs, sAct, sFs, fHs, fVs, fAct, fFs;

  int checks = 0;
  int errors = 0;
  bit bounceOn;

  int tCount;
  int mSx, mSy, mSdx, mSdy;
  int mFx, mFy, mFdx, mFdy;

  typedef struct {
    bit en;
    bit midPulse;
    int expCx;
    int expCy;
  } vec_t;

  vec_t vecs[11];

  circle_scan_controller #(
    .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
    .RADIUS(S_R), .STEP(S_STEP)
  ) dutSmall (
    .clk(clk), .rst(rst), .enable(enable),
    .hcount(sH), .vcount(sV), .hsync(sHs), .vsync(sVs),
    .active(sAct), .frame_start(sFs), .center_x(sCx), .center_y(sCy)
  );

  circle_scan_controller dutFull (
    .clk(clk), .rst(rst), .enable(enable),
    .hcount(fH), .vcount(fV), .hsync(fHs), .vsync(fVs),
    .active(fAct), .frame_start(fFs), .center_x(fCx), .center_y(fCy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void bounce(inout int pos, inout int dir, input int lo, input int hi,
                                 input int step);
    if (dir == 1) begin
      if (pos + step > hi) begin pos = hi; dir = 0; end
      else pos = pos + step;
    end else begin
      if (pos - step < lo) begin pos = lo; dir = 1; end
      else pos = pos - step;
    end
  endfunction

  task automatic resetModel();
    tCount = 0;
    mSx = S_HA / 2; mSy = S_VA / 2; mSdx = 1; mSdy = 1;
    mFx = 320;      mFy = 240;      mFdx = 1; mFdy = 1;
  endtask

  task automatic checkOne(input string tag, input int ht, input int vt, input int ha,
                          input int hf, input int hs, input int va, input int vf, input int vs,
                          input int ex, input int ey, input logic [9:0] h, input logic [9:0] v,
                          input logic ahs, input logic avs, input logic aact, input logic afs,
                          input logic [9:0] ax, input logic [9:0] ay);
    int eh, ev;
    eh = tCount % ht;
    ev = (tCount / ht) % vt;
    checkVal({tag, ".hcount"}, h, eh);
    checkVal({tag, ".vcount"}, v, ev);
    checkVal({tag, ".hsync"}, ahs, (eh >= ha + hf && eh < ha + hf + hs) ? 0 : 1);
    checkVal({tag, ".vsync"}, avs, (ev >= va + vf && ev < va + vf + vs) ? 0 : 1);
    checkVal({tag, ".active"}, aact, (!rst && eh < ha && ev < va) ? 1 : 0);
    checkVal({tag, ".frame_start"}, afs, (!rst && eh == 0 && ev == 0) ? 1 : 0);
    checkVal({tag, ".center_x"}, ax, ex);
    checkVal({tag, ".center_y"}, ay, ey);
  endtask

  task automatic checkOutput();
    checkOne("small", S_HT, S_VT, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS, mSx, mSy,
             sH, sV, sHs, sVs, sAct, sFs, sCx, sCy);
    checkOne("full", F_HT, F_VT, 640, 16, 96, 480, 10, 2, mFx, mFy,
             fH, fV, fHs, fVs, fAct, fFs, fCx, fCy);
  endtask

  // One clock: present enable, advance the model across the edge, then compare.
  task automatic applyStimulus(input logic en);
    enable = en;
    if (rst) begin
      resetModel();
    end else begin
      if (bounceOn && en && (tCount % S_FT == S_FT - 1)) begin
        bounce(mSx, mSdx, S_R, S_HA - 1 - S_R, S_STEP);
        bounce(mSy, mSdy, S_R, S_VA - 1 - S_R, S_STEP);
      end
      if (bounceOn && en && (tCount % F_FT == F_FT - 1)) begin
        bounce(mFx, mFdx, 50, 589, 2);
        bounce(mFy, mFdy, 50, 429, 2);
      end
      tCount++;
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    int expX, expY;
    bit found;
`ifdef CIRCLE_BOUNCE_EN
    bounceOn = 1'b1;
    vecs[0]  = '{1'b1, 1'b0, 10, 8};
    vecs[1]  = '{1'b1, 1'b0, 12, 8};
    vecs[2]  = '{1'b0, 1'b1, 12, 8};
    vecs[3]  = '{1'b0, 1'b0, 12, 8};
    vecs[4]  = '{1'b1, 1'b0, 12, 6};
    vecs[5]  = '{1'b1, 1'b0, 10, 4};
    vecs[6]  = '{1'b1, 1'b0, 8, 3};
    vecs[7]  = '{1'b1, 1'b0, 6, 5};
    vecs[8]  = '{1'b1, 1'b0, 4, 7};
    vecs[9]  = '{1'b1, 1'b0, 3, 8};
    vecs[10] = '{1'b1, 1'b0, 5, 6};
    expX = 10; expY = 8;
`else
    bounceOn = 1'b0;
    for (int i = 0; i < 11; i++) vecs[i] = '{(i != 2 && i != 3), (i == 2), 8, 6};
    expX = 8; expY = 6;
`endif

    rst = 1'b1;
    enable = 1'b0;
    resetModel();
    #2;
    checkOutput();
    repeat (3) applyStimulus(1'b0);
    checkVal("rstHsync", fHs, 1);
    checkVal("rstCenterXFull", fCx, 320);
    checkVal("rstCenterYFull", fCy, 240);

    rst = 1'b0;
    #1;
    checkOutput();
    checkVal("frameStartAfterRelease", sFs, 1);

    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < S_FT; k++) begin
        applyStimulus(vecs[i].midPulse ? (k == S_FT / 2) : vecs[i].en);
      end
      checkVal($sformatf("vec%0d.center_x", i), sCx, vecs[i].expCx);
      checkVal($sformatf("vec%0d.center_y", i), sCy, vecs[i].expCy);
      checkVal($sformatf("vec%0d.frame_start", i), sFs, 1);
    end

    // Reset in the middle of a frame, after several centre updates.
    found = 1'b0;
    for (int k = 0; k < S_FT && !found; k++) begin
      if ((tCount % S_HT == 12) && ((tCount / S_HT) % S_VT == 7)) found = 1'b1;
      else applyStimulus(1'b1);
    end
    checkVal("reachMidFrame", found, 1);
    rst = 1'b1;
    resetModel();
    #1;
    checkOutput();
    checkVal("midRstHcount", sH, 0);
    checkVal("midRstCenterX", sCx, S_HA / 2);
    checkVal("midRstCenterY", sCy, S_VA / 2);
    repeat (2) applyStimulus(1'b1);
    rst = 1'b0;
    #1;
    checkOutput();
    for (int k = 0; k < S_FT; k++) applyStimulus(1'b1);
    checkVal("afterRstUpdateX", sCx, expX);
    checkVal("afterRstUpdateY", sCy, expY);

    for (int k = 0; k < 40 * S_FT; k++) applyStimulus($urandom_range(0, 3) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/circle_scan_controller.md
# circle_scan_controller

Scan and animation controller for the circle renderer. Generates the 640x480@60 raster counters (`hcount`, `vcount`) and active-low syncs that drive the renderer. Once per frame it advances the circle centre along a bouncing trajectory, so the renderer receives stable centre coordinates for a whole frame. Sits between the pixel-clock domain root and the renderer/DAC stage.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal porch and sync widths
- `V_ACTIVE`, 480, visible lines
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical porch and sync widths
- `RADIUS`, 50, circle radius; bounds the centre travel
- `STEP`, 2, centre displacement per frame per axis; must be < `RADIUS`

Ports:
- `clk`  in  1  pixel clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  animation run; 0 freezes centre, raster keeps running
- `hcount`  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL = 800)
- `vcount`  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL = 525)
- `hsync`  out  1  active-low horizontal sync
- `vsync`  out  1  active-low vertical sync
- `active`  out  1  high when hcount < H_ACTIVE and vcount < V_ACTIVE
- `frame_start`  out  1  one-cycle pulse while counters read (0,0)
- `center_x`  out  10  circle centre X, constant for a frame
- `center_y`  out  10  circle centre Y, constant for a frame

## Operation
- Raster: `hcount` increments every cycle. At 799 it wraps to 0 and `vcount` increments. `vcount` wraps 524 -> 0 on the same edge that `hcount` wraps.
- `hsync` low for hcount 656..751. `vsync` low for vcount 490..491. Both are decoded from the registered counters, so they are aligned with them in the same cycle.
- Animation state: direction bits `dir_x`, `dir_y` (1 = increasing). Legal centre range is X in [RADIUS, H_ACTIVE-1-RADIUS] = [50, 589] and Y in [RADIUS, V_ACTIVE-1-RADIUS] = [50, 429].
- Update event: the cycle with hcount=799, vcount=524 (last cycle of the frame). If `enable`=1 on that cycle, each axis updates independently:
  - Increasing and centre+STEP > max: centre := max, direction flips to decreasing.
  - Decreasing and centre-STEP < min: centre := min, direction flips to increasing.
  - Otherwise centre := centre ± STEP.
- `enable` is sampled only on the update event. Toggling it mid-frame has no effect until the frame's last cycle.
- Arithmetic is done at 11 bits to avoid underflow/overflow. Outputs are truncated to 10 bits after clamping.

## Timing
- Reset values while `rst`=1: hcount=0, vcount=0, hsync=1, vsync=1, active=0, frame_start=0, center_x=320, center_y=240, dir_x=1, dir_y=1.
- `active` and `frame_start` are forced low while `rst` is high. They take their decoded values from the first cycle after release.
- `frame_start` is high on the first cycle after reset release, then every 420000 cycles.
- A centre update is visible from the first cycle of the next frame (same edge on which the counters become (0,0)), together with `frame_start`. Centre never changes mid-frame.
- Reset asserted mid-frame immediately returns all state to reset values, including the direction bits. Nothing from the partial frame is retained.

## Configuration
- `CIRCLE_BOUNCE_EN` defined: animation logic as above.
- Not defined: no direction state or update logic is built. `center_x`=320 and `center_y`=240 are constant, `enable` is ignored, and raster behaviour is unchanged.

## Test plan
- Reset release -> hcount/vcount count from 0, `frame_start`=1 on first cycle, next `frame_start` exactly 420000 cycles later. `hsync` low for exactly 96 cycles starting at hcount=656. `vsync` low for exactly 1600 cycles starting at vcount=490, hcount=0.
- `enable`=1 from reset, 3 frames -> centre (322,242), (324,244), (326,246), each changing on the `frame_start` edge.
- X bounce: run `enable`=1 until center_x reaches 588 moving up -> next frame 589 with dir_x flipped, following frame 587. Y behaves likewise at 429, and at the lower bound 50.
- `enable` pulsed high mid-frame only, low at the frame's last cycle -> centre unchanged. `enable` held low for 5 frames -> centre frozen, raster unaffected.
- `rst` asserted at hcount=400, vcount=300 after several updates -> all outputs return to reset values in the same cycle. After release, first update gives (322,242).
- Build without `CIRCLE_BOUNCE_EN`, `enable`=1 for 10 frames -> centre stays (320,240), raster checks identical to the first scenario.
